// File: rtl/multi_cycle_addsub_if.sv
// Operand/result bundle for multi_cycle_addsub.
// Optional macro ADDSUB_SATURATE_EN adds the sat request bit.
interface multi_cycle_addsub_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
`ifdef ADDSUB_SATURATE_EN
  logic             sat;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             c_out;
  logic             overflow;
  logic             zero;

  modport master (
    output start, sub, a, b,
`ifdef ADDSUB_SATURATE_EN
    output sat,
`endif
    input  busy, done, result, c_out, overflow, zero
  );

  modport slave (
    input  start, sub, a, b,
`ifdef ADDSUB_SATURATE_EN
    input  sat,
`endif
    output busy, done, result, c_out, overflow, zero
  );
endinterface

// File: rtl/multi_cycle_addsub.sv
// Chunk-serial adder/subtractor: WIDTH bits, CHUNK bits per cycle, LSB chunk
// first, carry registered between chunks. start/busy/done handshake with
// carry, signed overflow and zero flags.
// Optional macro ADDSUB_SATURATE_EN: clamp signed overflow when sat is latched.
module multi_cycle_addsub #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic                  clock,
  input  logic                  reset_n,
  multi_cycle_addsub_if.slave   bus
);
  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0]    LAST = CW'(N - 1);
  localparam logic [WIDTH-1:0] MAXP = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MAXN = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic             cout_q, cout_d, ovf_q, ovf_d, zero_q, zero_d;
`ifdef ADDSUB_SATURATE_EN
  logic             sat_q, sat_d;
`endif

  logic [CHUNK-1:0] ca, cb;
  logic [CHUNK:0]   sum;
  logic             msb_cin;

  // Next-state: accept in IDLE/DONE, one chunk per edge in RUN, flags on the last chunk
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
`ifdef ADDSUB_SATURATE_EN
    sat_d   = sat_q;
`endif
    ca      = a_q[int'(cnt_q)*CHUNK +: CHUNK];
    cb      = b_q[int'(cnt_q)*CHUNK +: CHUNK];
    sum     = {1'b0, ca} + {1'b0, cb} + (CHUNK+1)'(carry_q);
    // carry into the chunk MSB recovered from the MSB sum bit
    msb_cin = ca[CHUNK-1] ^ cb[CHUNK-1] ^ sum[CHUNK-1];

    case (state_q)
      RUN: begin
        res_d[int'(cnt_q)*CHUNK +: CHUNK] = sum[CHUNK-1:0];
        carry_d = sum[CHUNK];
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          cout_d = sum[CHUNK];
          ovf_d  = msb_cin ^ sum[CHUNK];
`ifdef ADDSUB_SATURATE_EN
          if (sat_q && ovf_d) res_d = a_q[WIDTH-1] ? MAXN : MAXP;
`endif
          zero_d  = (res_d == '0);
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        if (bus.start) begin
          // subtraction is a + ~b + 1: invert b here, seed the carry with sub
          a_d     = bus.a;
          b_d     = bus.b ^ {WIDTH{bus.sub}};
          carry_d = bus.sub;
          cnt_d   = '0;
          res_d   = '0;
`ifdef ADDSUB_SATURATE_EN
          sat_d   = bus.sat;
`endif
          state_d = RUN;
          busy_d  = 1'b1;
        end
      end
    endcase
  end

  // State registers, async active-low clear aborts any operation in flight
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
`ifdef ADDSUB_SATURATE_EN
      sat_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
`ifdef ADDSUB_SATURATE_EN
      sat_q   <= sat_d;
`endif
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.result   = res_q;
  assign bus.c_out    = cout_q;
  assign bus.overflow = ovf_q;
  assign bus.zero     = zero_q;
endmodule

// File: tb/tb_multi_cycle_addsub.sv
// Scoreboard bench for multi_cycle_addsub: a CHUNK=8 and a CHUNK=32 instance,
// both WIDTH=32, checked against an integer-arithmetic reference model.
module tb_multi_cycle_addsub;
`ifdef ADDSUB_SATURATE_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  typedef struct {
    logic [31:0] res;
    logic        co, ov, z;
    longint      cyc;
  } exp_t;

  logic   clock = 1'b0;
  logic   reset_n = 1'b0;
  longint cyc = 0;
  int     n_cmp = 0;
  int     n_bad = 0;
  exp_t   exp_q[2][$];

  multi_cycle_addsub_if #(.WIDTH(32)) bus8();
  multi_cycle_addsub_if #(.WIDTH(32)) bus32();

  multi_cycle_addsub #(.WIDTH(32), .CHUNK(8))  dut8  (.clock(clock), .reset_n(reset_n), .bus(bus8));
  multi_cycle_addsub #(.WIDTH(32), .CHUNK(32)) dut32 (.clock(clock), .reset_n(reset_n), .bus(bus32));

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain signed/unsigned integer arithmetic on 64-bit values
  function automatic exp_t model(input logic [31:0] a, b, input logic s, input logic st);
    exp_t   m;
    longint sr, ur;
    sr = s ? (longint'($signed(a)) - longint'($signed(b)))
           : (longint'($signed(a)) + longint'($signed(b)));
    ur = longint'(a) + longint'(b);
    m.res = sr[31:0];
    m.co  = s ? (longint'(a) >= longint'(b)) : ur[32];
    m.ov  = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
    if (st && SAT_EN && m.ov) m.res = a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    m.z   = (m.res == 32'd0);
    m.cyc = 0;
    return m;
  endfunction

  task automatic drive(input int d, input logic st, input logic [31:0] a, b,
                       input logic s, input logic sat);
    if (d == 0) begin
      bus8.start = st; bus8.a = a; bus8.b = b; bus8.sub = s;
`ifdef ADDSUB_SATURATE_EN
      bus8.sat = sat;
`endif
    end else begin
      bus32.start = st; bus32.a = a; bus32.b = b; bus32.sub = s;
`ifdef ADDSUB_SATURATE_EN
      bus32.sat = sat;
`endif
    end
  endtask

  function automatic logic get_busy(input int d);
    return (d == 0) ? bus8.busy : bus32.busy;
  endfunction

  function automatic logic get_done(input int d);
    return (d == 0) ? bus8.done : bus32.done;
  endfunction

  // Called at a negedge; returns at the negedge after the start edge
  task automatic issue(input int d, input logic [31:0] a, b, input logic s,
                       input logic st, input bit expect_done);
    exp_t e;
    drive(d, 1'b1, a, b, s, st);
    if (expect_done) begin
      e = model(a, b, s, st);
      e.cyc = cyc + 1 + ((d == 0) ? 4 : 1);
      exp_q[d].push_back(e);
    end
    @(negedge clock);
    drive(d, 1'b0, $urandom, $urandom, 1'($urandom), 1'($urandom));
  endtask

  task automatic wait_idle(input int d);
    for (int i = 0; i < 50; i++) begin
      if (!get_busy(d)) return;
      @(negedge clock);
    end
    chk("busy_timeout", 64'(get_busy(d)), 64'd0);
  endtask

  task automatic wait_done(input int d);
    for (int i = 0; i < 50; i++) begin
      if (get_done(d)) return;
      @(negedge clock);
    end
    chk("done_timeout", 64'(get_done(d)), 64'd1);
  endtask

  task automatic check_done(input int d, input logic [31:0] r, input logic co, ov, z);
    exp_t e;
    if (exp_q[d].size() == 0) begin
      chk($sformatf("unexpected_done%0d", d), 64'd1, 64'd0);
      return;
    end
    e = exp_q[d].pop_front();
    chk($sformatf("result%0d", d),   64'(r),   64'(e.res));
    chk($sformatf("c_out%0d", d),    64'(co),  64'(e.co));
    chk($sformatf("overflow%0d", d), 64'(ov),  64'(e.ov));
    chk($sformatf("zero%0d", d),     64'(z),   64'(e.z));
    chk($sformatf("latency%0d", d),  64'(cyc), 64'(e.cyc));
  endtask

  // Monitors: every done pulse must match the oldest outstanding expectation
  always @(negedge clock)
    if (reset_n && bus8.done) check_done(0, bus8.result, bus8.c_out, bus8.overflow, bus8.zero);
  always @(negedge clock)
    if (reset_n && bus32.done) check_done(1, bus32.result, bus32.c_out, bus32.overflow, bus32.zero);

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    drive(0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    drive(1, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    #3;
    chk("rst_busy",   64'(bus8.busy),   64'd0);
    chk("rst_done",   64'(bus8.done),   64'd0);
    chk("rst_result", 64'(bus8.result), 64'd0);
    chk("rst_flags",  64'({bus8.c_out, bus8.overflow, bus8.zero}), 64'd0);
    chk("rst_result32", 64'(bus32.result), 64'd0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);

    fork
      begin
        issue(0, 32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 1'b1);
        chk("busy_after_start", 64'(bus8.busy), 64'd1);
        chk("done_low_in_run",  64'(bus8.done), 64'd0);
        wait_idle(0);
        issue(0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b1); wait_idle(0);
        issue(0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b1, 1'b1); wait_idle(0);
        issue(0, 32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1, 1'b1); wait_idle(0);
        issue(0, 32'd5, 32'd5, 1'b1, 1'b0, 1'b1); wait_idle(0);
        issue(0, 32'd3, 32'd5, 1'b1, 1'b0, 1'b1); wait_idle(0);
        // start while busy must be ignored
        issue(0, 32'h1234_0000, 32'h0000_5678, 1'b0, 1'b0, 1'b1);
        issue(0, 32'hDEAD_BEEF, 32'h1111_1111, 1'b1, 1'b0, 1'b0);
        wait_idle(0);
        // start in the done cycle runs back-to-back
        @(negedge clock);
        issue(0, 32'hFFFF_FFFF, 32'h0000_0002, 1'b0, 1'b0, 1'b1);
        wait_done(0);
        issue(0, 32'h0000_0010, 32'h0000_0020, 1'b1, 1'b0, 1'b1);
        wait_idle(0);
        for (int i = 0; i < 40; i++) begin
          issue(0, $urandom, $urandom, 1'($urandom), 1'($urandom), 1'b1);
          wait_idle(0);
          repeat ($urandom_range(0, 2)) @(negedge clock);
        end
      end
      begin
        issue(1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b1); wait_idle(1);
        issue(1, 32'd3, 32'd5, 1'b1, 1'b0, 1'b1); wait_idle(1);
        for (int i = 0; i < 20; i++) begin
          issue(1, $urandom, $urandom, 1'($urandom), 1'($urandom), 1'b1);
          wait_idle(1);
          repeat ($urandom_range(0, 2)) @(negedge clock);
        end
      end
    join
    wait_idle(0);
    wait_idle(1);
    repeat (3) @(negedge clock);

    // leave every flag set, then abort an operation mid-run
    issue(0, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 1'b1);
    wait_idle(0);
    @(negedge clock);
    issue(0, 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 1'b0);
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    chk("abort_busy",   64'(bus8.busy),   64'd0);
    chk("abort_done",   64'(bus8.done),   64'd0);
    chk("abort_result", 64'(bus8.result), 64'd0);
    chk("abort_flags",  64'({bus8.c_out, bus8.overflow, bus8.zero}), 64'd0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    repeat (6) @(negedge clock);
    issue(0, 32'h0000_0001, 32'h0000_0002, 1'b1, 1'b0, 1'b1);
    wait_idle(0);
    repeat (3) @(negedge clock);

    chk("pending8",  64'(exp_q[0].size()), 64'd0);
    chk("pending32", 64'(exp_q[1].size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
